// File: rtl/decode_scan.sv
// Purpose: registered one-hot decoder with a direct mode and a self-running scan mode.
// Latency: one cycle from x/en/mode/dwell to y, idx, wrap and err. No input reaches an output combinationally.
// Backpressure: none. The block has no handshake. en low freezes the scan and forces y and wrap to 0.
module decode_scan #(
  parameter int SEL_W   = 5,
  parameter int OUT_W   = 32,
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   x,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               err
);

  // OUT_W must fit within the index space and have at least two outputs.
  if (OUT_W < 2 || OUT_W > (1 << SEL_W)) begin : g_cfg_err
    $error("decode_scan: OUT_W must be in 2..2**SEL_W");
  end

  // The range limit is one bit wider than the index, so OUT_W == 2**SEL_W fits.
  localparam logic [SEL_W:0]   OUT_LIM  = (SEL_W+1)'(OUT_W);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

  logic [SEL_W-1:0]   idx_q, idx_nxt;
  logic [DWELL_W-1:0] cnt_q, cnt_nxt;
  logic               mode_q;
  logic [OUT_W-1:0]   y_nxt;
  logic               wrap_nxt, err_nxt;

  // Decode only bits 0..OUT_W-1. An index outside that range yields all-zero.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    onehot = '0;
    if ({1'b0, i} < OUT_LIM) onehot = OUT_W'(1) << i;
  endfunction

  // Next-state selection: direct decode, scan entry, scan run, or scan paused.
  always_comb begin
    idx_nxt  = idx_q;
    cnt_nxt  = cnt_q;
    y_nxt    = '0;
    wrap_nxt = 1'b0;
    err_nxt  = 1'b0;
    if (!mode) begin
      idx_nxt = x;
      cnt_nxt = '0;
      if (en) begin
        if ({1'b0, x} < OUT_LIM) y_nxt = onehot(x);
        else                     err_nxt = 1'b1;
      end
    end else if (!mode_q) begin
      // A rising mode always restarts the scan at index 0 with a fresh dwell count.
      idx_nxt = '0;
      cnt_nxt = '0;
      if (en) y_nxt = onehot(SEL_W'(0));
    end else if (en) begin
      // The >= compare means a lowered dwell advances the index right away when cnt is already past it.
      if (cnt_q >= dwell) begin
        cnt_nxt = '0;
        if (idx_q == LAST_IDX) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx_q + SEL_W'(1);
        end
      end else begin
        cnt_nxt = cnt_q + DWELL_W'(1);
      end
      y_nxt = onehot(idx_nxt);
    end
    // With mode=1, mode_q=1 and en=0 the scan is paused: idx and cnt hold and the outputs stay at 0.
  end

  // State and output registers. Reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      y      <= '0;
      wrap   <= 1'b0;
      err    <= 1'b0;
    end else begin
      idx_q  <= idx_nxt;
      cnt_q  <= cnt_nxt;
      mode_q <= mode;
      y      <= y_nxt;
      wrap   <= wrap_nxt;
      err    <= err_nxt;
    end
  end

  assign idx = idx_q;

endmodule

// File: tb/tb_decode_scan.sv
// Directed bench for decode_scan using three configurations: 5/32, 3/5 and 2/4.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the same point.
module tb_decode_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: SEL_W=5, OUT_W=32.
  logic        en_a, mode_a;
  logic [4:0]  x_a;
  logic [15:0] dwell_a;
  logic [31:0] y_a;
  logic [4:0]  idx_a;
  logic        wrap_a, err_a;

  // Instance B: SEL_W=3, OUT_W=5.
  logic        en_b, mode_b;
  logic [2:0]  x_b;
  logic [15:0] dwell_b;
  logic [4:0]  y_b;
  logic [2:0]  idx_b;
  logic        wrap_b, err_b;

  // Instance C: SEL_W=2, OUT_W=4.
  logic        en_c, mode_c;
  logic [1:0]  x_c;
  logic [15:0] dwell_c;
  logic [3:0]  y_c;
  logic [1:0]  idx_c;
  logic        wrap_c, err_c;

  decode_scan #(.SEL_W(5), .OUT_W(32), .DWELL_W(16)) u_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .x(x_a), .dwell(dwell_a),
    .y(y_a), .idx(idx_a), .wrap(wrap_a), .err(err_a));

  decode_scan #(.SEL_W(3), .OUT_W(5), .DWELL_W(16)) u_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .x(x_b), .dwell(dwell_b),
    .y(y_b), .idx(idx_b), .wrap(wrap_b), .err(err_b));

  decode_scan #(.SEL_W(2), .OUT_W(4), .DWELL_W(16)) u_c (
    .clk(clk), .rst(rst), .en(en_c), .mode(mode_c), .x(x_c), .dwell(dwell_c),
    .y(y_c), .idx(idx_c), .wrap(wrap_c), .err(err_c));

  int checks = 0;
  int errors = 0;

  // Every comparison in the bench goes through this task.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Wait for the next rising edge, then move 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b1; mode_a = 1'b0; x_a = 5'd7; dwell_a = '0;
    en_b = 1'b1; mode_b = 1'b0; x_b = 3'd7; dwell_b = '0;
    en_c = 1'b1; mode_c = 1'b0; x_c = 2'd1; dwell_c = '0;

    // Reset holds every output at 0 even with en=1 and x=7.
    tick(); tick();
    chk("rst_y",    y_a,    32'h0);
    chk("rst_idx",  idx_a,  32'h0);
    chk("rst_wrap", wrap_a, 32'h0);
    chk("rst_err",  err_a,  32'h0);
    rst = 1'b0;
    tick();
    chk("rel_y",   y_a,   32'h0000_0080);
    chk("rel_idx", idx_a, 32'd7);

    // Direct sweep on instance A, then one cycle with en low.
    for (int i = 0; i < 32; i++) begin
      x_a = 5'(i);
      tick();
      chk("sweep_y", y_a, 32'h1 << i);
    end
    chk("sweep_err", err_a, 32'h0);
    en_a = 1'b0;
    tick();
    chk("dis_y", y_a, 32'h0);

    // Out-of-range index on instance B (OUT_W=5).
    x_b = 3'd6;
    tick();
    chk("oor_y",   y_b,   32'h0);
    chk("oor_err", err_b, 32'h1);
    x_b = 3'd4;
    tick();
    chk("top_y",   y_b,   32'h10);
    chk("top_err", err_b, 32'h0);
    chk("top_idx", idx_b, 32'd4);

    // Scan on instance C with dwell=2. Each index is held 3 cycles, giving a 12-cycle period.
    dwell_c = 16'd2;
    mode_c  = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      chk("scan_y",    y_c,   32'h1 << ((k / 3) % 4));
      chk("scan_idx",  idx_c, 32'((k / 3) % 4));
      chk("scan_wrap", wrap_c, (k > 0 && (k % 12) == 0) ? 32'h1 : 32'h0);
    end
    // Here idx=3 and cnt=2. With dwell=0 the scan wraps on the next edge, then steps every cycle.
    dwell_c = 16'd0;
    tick();
    chk("d0_y0", y_c, 32'h1);
    chk("d0_wrap", wrap_c, 32'h1);
    tick();
    chk("d0_y1", y_c, 32'h2);
    chk("d0_wrap1", wrap_c, 32'h0);
    tick();
    chk("d0_y2", y_c, 32'h4);

    // Pause at idx=2, then resume from the held position.
    en_c = 1'b0;
    tick();
    chk("pause_y",   y_c,   32'h0);
    chk("pause_idx", idx_c, 32'd2);
    tick();
    chk("pause_idx2", idx_c, 32'd2);
    en_c = 1'b1;
    tick();
    chk("resume_y", y_c, 32'h8);

    // Toggling mode 1 to 0 to 1 restarts the scan.
    mode_c = 1'b0;
    tick();
    chk("dir_y", y_c, 32'h2);
    mode_c = 1'b1;
    tick();
    chk("restart_y",   y_c,   32'h1);
    chk("restart_idx", idx_c, 32'd0);

    // Set dwell=10 and count up to cnt=5. Lowering dwell to 1 then advances on the next edge.
    dwell_c = 16'd10;
    for (int k = 0; k < 5; k++) tick();
    chk("long_y", y_c, 32'h1);
    dwell_c = 16'd1;
    tick();
    chk("cut_y",   y_c,   32'h2);
    chk("cut_idx", idx_c, 32'd1);

    // Reset asserted mid-scan, then the scan restarts at bit 0.
    rst = 1'b1;
    tick();
    chk("mrst_y",    y_c,    32'h0);
    chk("mrst_idx",  idx_c,  32'h0);
    chk("mrst_wrap", wrap_c, 32'h0);
    chk("mrst_err",  err_c,  32'h0);
    rst = 1'b0;
    tick();
    chk("post_y0", y_c, 32'h1);
    tick();
    chk("post_y1", y_c, 32'h1);
    tick();
    chk("post_y2", y_c, 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
